dds_spi_loader: RTL and testbench

Upstream front end of the `dds` core. Receives serial words on `spi_clk`/`spi_data`, framed by `freq_cs` or `phaseshift_cs`, and oversamples them in the `sys_clk` domain. When a frame closes, it commits the word as either a frequency tuning word or a phase-shift word, each with a one-cycle valid strobe that the DDS core uses to load its phase accumulator and offset registers.

---
 rtl/dds_pkg.sv | 39 +++
 rtl/dds_sync2.sv | 31 +++
 rtl/dds_spi_loader.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_dds_spi_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared types and constants for the DDS serial front end.
//   SYNC_STAGES  : depth of the input synchronizers
//   BITCNT_W     : width of the saturating received-bit counter
//   dds_state_e  : loader FSM states (IDLE, SHIFT, COMMIT, ABORT)
//   dds_target_e : which word an open frame is destined for
//   bitcnt_inc() : saturating increment of the bit counter
// -----------------------------------------------------------------------------
package dds_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int BITCNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        ABORT  = 2'd3
    } dds_state_e;

    typedef enum logic {
        TGT_FREQ  = 1'b0,
        TGT_PHASE = 1'b1
    } dds_target_e;

    // Counter sticks at all-ones so overlong frames never wrap back to a
    // count that could look like a valid (or zero) length.
    function automatic logic [BITCNT_W-1:0] bitcnt_inc(input logic [BITCNT_W-1:0] cnt);
        logic [BITCNT_W-1:0] res;
        if (cnt == {BITCNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(BITCNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/dds_sync2.sv
// -----------------------------------------------------------------------------
// dds_sync2
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears the chain to 0
//   d     : asynchronous input
//   q     : synchronized output (SYNC_STAGES clk cycles of latency)
// -----------------------------------------------------------------------------
module dds_sync2
    import dds_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Metastability-settling shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/dds_spi_loader.sv
// -----------------------------------------------------------------------------
// dds_spi_loader
// Serial front end of the DDS core. Oversamples a simple chip-select framed
// serial link in the sys_clk domain and commits each closed frame either as a
// frequency tuning word or as a phase-shift word, each with a one-cycle strobe.
//
// Parameters:
//   ACC_LENGTH    : frequency word / phase accumulator width
//   PHASE_LENGTH  : phase-shift word width
// Ports:
//   sys_clk       : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   spi_clk       : serial clock (async), data sampled on its rising edge
//   spi_data      : serial data, MSB first
//   freq_cs       : active-high frame select for the frequency word
//   phaseshift_cs : active-high frame select for the phase word
//   freq_word     : last committed frequency word
//   freq_valid    : one-cycle pulse when freq_word updates
//   phase_word    : last committed phase word
//   phase_valid   : one-cycle pulse when phase_word updates
//   busy          : high while a frame is open (SHIFT or ABORT)
//   frame_err     : one-cycle pulse when a frame is discarded
//
// Build option:
//   DDS_SPI_STRICT_LEN_EN : when defined, a frame commits only if exactly
//   ACC_LENGTH (freq) or PHASE_LENGTH (phase) bits were received; otherwise
//   any non-empty frame commits (short frames zero-extended, long frames keep
//   the most recent bits).
// -----------------------------------------------------------------------------
module dds_spi_loader
    import dds_pkg::*;
#(
    parameter int ACC_LENGTH   = 16,
    parameter int PHASE_LENGTH = 8
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    spi_clk,
    input  logic                    spi_data,
    input  logic                    freq_cs,
    input  logic                    phaseshift_cs,
    output logic [ACC_LENGTH-1:0]   freq_word,
    output logic                    freq_valid,
    output logic [PHASE_LENGTH-1:0] phase_word,
    output logic                    phase_valid,
    output logic                    busy,
    output logic                    frame_err
);

    // ------------------------------------------------------------------
    // Synchronized inputs and their one-cycle-delayed copies
    // ------------------------------------------------------------------
    logic spi_clk_s;
    logic spi_data_s;
    logic freq_cs_s;
    logic phase_cs_s;

    logic spi_clk_d_r;
    logic freq_cs_d_r;
    logic phase_cs_d_r;

    logic spi_rise_s;
    logic freq_rise_s;
    logic freq_fall_s;
    logic phase_rise_s;
    logic phase_fall_s;

    // ------------------------------------------------------------------
    // FSM and datapath state
    // ------------------------------------------------------------------
    dds_state_e              state_r;
    dds_state_e              state_nxt_s;
    dds_target_e             target_r;
    dds_target_e             target_nxt_s;

    logic [ACC_LENGTH-1:0]   shift_r;
    logic [BITCNT_W-1:0]     bitcnt_r;
    logic [BITCNT_W-1:0]     bitcnt_upd_s;

    logic                    other_rise_s;
    logic                    tgt_fall_s;
    logic                    len_ok_s;

    logic [ACC_LENGTH-1:0]   freq_word_r;
    logic                    freq_valid_r;
    logic [PHASE_LENGTH-1:0] phase_word_r;
    logic                    phase_valid_r;
    logic                    busy_r;
    logic                    frame_err_r;

    dds_sync2 u_sync_spi_clk (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d     (spi_clk),
        .q     (spi_clk_s)
    );

    dds_sync2 u_sync_spi_data (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d     (spi_data),
        .q     (spi_data_s)
    );

    dds_sync2 u_sync_freq_cs (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d     (freq_cs),
        .q     (freq_cs_s)
    );

    dds_sync2 u_sync_phase_cs (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d     (phaseshift_cs),
        .q     (phase_cs_s)
    );

    // Third registered copy of the edge-carrying signals for edge detection.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_clk_d_r  <= 1'b0;
            freq_cs_d_r  <= 1'b0;
            phase_cs_d_r <= 1'b0;
        end else begin
            spi_clk_d_r  <= spi_clk_s;
            freq_cs_d_r  <= freq_cs_s;
            phase_cs_d_r <= phase_cs_s;
        end
    end

    assign spi_rise_s   =  spi_clk_s  & ~spi_clk_d_r;
    assign freq_rise_s  =  freq_cs_s  & ~freq_cs_d_r;
    assign freq_fall_s  = ~freq_cs_s  &  freq_cs_d_r;
    assign phase_rise_s =  phase_cs_s & ~phase_cs_d_r;
    assign phase_fall_s = ~phase_cs_s &  phase_cs_d_r;

    // Edge events resolved against the current frame's target.
    always_comb begin
        other_rise_s = 1'b0;
        tgt_fall_s   = 1'b0;
        if (target_r == TGT_FREQ) begin
            other_rise_s = phase_rise_s;
            tgt_fall_s   = freq_fall_s;
        end else begin
            other_rise_s = freq_rise_s;
            tgt_fall_s   = phase_fall_s;
        end
    end

    // Bit count including a spi_clk edge landing in this very cycle, so a cs
    // fall coincident with the last clock edge still counts that bit.
    always_comb begin
        bitcnt_upd_s = bitcnt_r;
        if (spi_rise_s) begin
            bitcnt_upd_s = bitcnt_inc(bitcnt_r);
        end else begin
            bitcnt_upd_s = bitcnt_r;
        end
    end

    // Frame length acceptance at commit time.
    always_comb begin
        len_ok_s = 1'b0;
`ifdef DDS_SPI_STRICT_LEN_EN
        if (target_r == TGT_FREQ) begin
            len_ok_s = (bitcnt_upd_s == BITCNT_W'(ACC_LENGTH));
        end else begin
            len_ok_s = (bitcnt_upd_s == BITCNT_W'(PHASE_LENGTH));
        end
`else
        if (bitcnt_upd_s != {BITCNT_W{1'b0}}) begin
            len_ok_s = 1'b1;
        end else begin
            len_ok_s = 1'b0;
        end
`endif
    end

    // Next-state logic of the frame FSM.
    always_comb begin
        state_nxt_s  = state_r;
        target_nxt_s = target_r;
        case (state_r)
            IDLE: begin
                if (freq_rise_s && phase_rise_s) begin
                    state_nxt_s = ABORT;
                end else if (freq_rise_s) begin
                    state_nxt_s  = SHIFT;
                    target_nxt_s = TGT_FREQ;
                end else if (phase_rise_s) begin
                    state_nxt_s  = SHIFT;
                    target_nxt_s = TGT_PHASE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                // A competing frame select wins over a simultaneous close.
                if (other_rise_s) begin
                    state_nxt_s = ABORT;
                end else if (tgt_fall_s) begin
                    if (len_ok_s) begin
                        state_nxt_s = COMMIT;
                    end else begin
                        state_nxt_s = ABORT;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            COMMIT: begin
                state_nxt_s = IDLE;
            end
            ABORT: begin
                // Hold until the link is quiet so a lingering cs does not
                // open a spurious frame.
                if (!freq_cs_s && !phase_cs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ABORT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and frame target registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            target_r <= TGT_FREQ;
        end else begin
            state_r  <= state_nxt_s;
            target_r <= target_nxt_s;
        end
    end

    // Shift register and saturating bit counter; cleared on frame open.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r  <= {ACC_LENGTH{1'b0}};
            bitcnt_r <= {BITCNT_W{1'b0}};
        end else if ((state_r == IDLE) && (state_nxt_s == SHIFT)) begin
            shift_r  <= {ACC_LENGTH{1'b0}};
            bitcnt_r <= {BITCNT_W{1'b0}};
        end else if ((state_r == SHIFT) && spi_rise_s) begin
            shift_r  <= {shift_r[ACC_LENGTH-2:0], spi_data_s};
            bitcnt_r <= bitcnt_upd_s;
        end else begin
            shift_r  <= shift_r;
            bitcnt_r <= bitcnt_r;
        end
    end

    // Committed words and their strobes.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_word_r   <= {ACC_LENGTH{1'b0}};
            phase_word_r  <= {PHASE_LENGTH{1'b0}};
            freq_valid_r  <= 1'b0;
            phase_valid_r <= 1'b0;
        end else if (state_r == COMMIT) begin
            case (target_r)
                TGT_FREQ: begin
                    freq_word_r   <= shift_r;
                    freq_valid_r  <= 1'b1;
                    phase_valid_r <= 1'b0;
                end
                TGT_PHASE: begin
                    phase_word_r  <= shift_r[PHASE_LENGTH-1:0];
                    phase_valid_r <= 1'b1;
                    freq_valid_r  <= 1'b0;
                end
                default: begin
                    freq_valid_r  <= 1'b0;
                    phase_valid_r <= 1'b0;
                end
            endcase
        end else begin
            freq_valid_r  <= 1'b0;
            phase_valid_r <= 1'b0;
        end
    end

    // Status flags registered from the next state so they line up with it;
    // frame_err fires only on entry to ABORT, not while waiting there.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            busy_r      <= (state_nxt_s == SHIFT) || (state_nxt_s == ABORT);
            frame_err_r <= (state_nxt_s == ABORT) && (state_r != ABORT);
        end
    end

    assign freq_word   = freq_word_r;
    assign freq_valid  = freq_valid_r;
    assign phase_word  = phase_word_r;
    assign phase_valid = phase_valid_r;
    assign busy        = busy_r;
    assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_dds_spi_loader.sv
// -----------------------------------------------------------------------------
// tb_dds_spi_loader
// Scoreboard bench: the stimulus side pushes the expected outcome of every
// frame (word, kind, strobe cycle); an independent monitor pops on each strobe.
// -----------------------------------------------------------------------------
module tb_dds_spi_loader;

    localparam int K_FREQ  = 0;
    localparam int K_PHASE = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int          kind;
        logic [15:0] word;
        int          exp_cyc;   // -1: no latency check
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        spi_clk;
    logic        spi_data;
    logic        freq_cs;
    logic        phaseshift_cs;
    logic [15:0] freq_word;
    logic        freq_valid;
    logic [7:0]  phase_word;
    logic        phase_valid;
    logic        busy;
    logic        frame_err;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    exp_t        exp_q[$];
    logic [15:0] mdl_freq  = 16'h0000;
    logic [7:0]  mdl_phase = 8'h00;

    dds_spi_loader dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .spi_clk       (spi_clk),
        .spi_data      (spi_data),
        .freq_cs       (freq_cs),
        .phaseshift_cs (phaseshift_cs),
        .freq_word     (freq_word),
        .freq_valid    (freq_valid),
        .phase_word    (phase_word),
        .phase_valid   (phase_valid),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Reference: the last bits received, zero-extended; empty (or wrong
    // length in the strict build) frames are discarded.
    task automatic push_expect(input int tgt, input logic [63:0] v, input int n);
        exp_t e;
        bit   ok;
        ok = (n >= 1);
`ifdef DDS_SPI_STRICT_LEN_EN
        ok = (tgt == K_FREQ) ? (n == 16) : (n == 8);
`endif
        if (!ok) begin
            e.kind = K_ERR; e.word = 16'h0000; e.exp_cyc = -1;
        end else if (tgt == K_FREQ) begin
            e.kind = K_FREQ; e.word = v[15:0]; e.exp_cyc = cyc + 4;
        end else begin
            e.kind = K_PHASE; e.word = {8'h00, v[7:0]}; e.exp_cyc = cyc + 4;
        end
        exp_q.push_back(e);
    endtask

    task automatic set_cs(input int tgt, input logic val);
        if (tgt == K_FREQ) freq_cs = val;
        else               phaseshift_cs = val;
    endtask

    task automatic send_bit(input logic b);
        spi_data = b;
        wait_cyc(5);
        spi_clk = 1'b1;
        wait_cyc(5);
        spi_clk = 1'b0;
    endtask

    // One complete frame; same_edge drops cs together with the last clock rise.
    task automatic frame(input int tgt, input logic [63:0] v, input int n, input bit same_edge);
        set_cs(tgt, 1'b1);
        wait_cyc(4);
        chk("busy_open", {31'd0, busy}, 32'd1);
        wait_cyc(2);
        for (int i = n - 1; i >= 1; i--) send_bit(v[i]);
        if (n >= 1 && same_edge) begin
            spi_data = v[0];
            wait_cyc(5);
            spi_clk = 1'b1;
            set_cs(tgt, 1'b0);
            push_expect(tgt, v, n);
            wait_cyc(5);
            spi_clk = 1'b0;
        end else begin
            if (n >= 1) send_bit(v[0]);
            set_cs(tgt, 1'b0);
            push_expect(tgt, v, n);
        end
        wait_cyc(8);
        chk("busy_closed", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge sys_clk) begin : monitor
        exp_t e;
        int   kind;
        if (rst_n && (freq_valid || phase_valid || frame_err)) begin
            kind = freq_valid ? K_FREQ : (phase_valid ? K_PHASE : K_ERR);
            chk("one_strobe", 32'(freq_valid) + 32'(phase_valid) + 32'(frame_err), 32'd1);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: got kind %0d required none (t=%0t)", kind, $time);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", 32'(kind), 32'(e.kind));
                if (e.kind == K_FREQ) mdl_freq = e.word;
                else if (e.kind == K_PHASE) mdl_phase = e.word[7:0];
                chk("freq_word", {16'd0, freq_word}, {16'd0, mdl_freq});
                chk("phase_word", {24'd0, phase_word}, {24'd0, mdl_phase});
                if (e.exp_cyc >= 0) chk("latency_cycle", 32'(cyc), 32'(e.exp_cyc));
            end
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: got timeout required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [63:0] v;
        int          n;
        int          tgt;
        rst_n = 1'b0; spi_clk = 1'b0; spi_data = 1'b0;
        freq_cs = 1'b0; phaseshift_cs = 1'b0;
        wait_cyc(3);
        chk("reset_outputs", {freq_word, phase_word, freq_valid, phase_valid, busy, frame_err, 4'd0}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Directed frames.
        frame(K_FREQ, 64'hA5C3, 16, 1'b0);
        frame(K_PHASE, 64'h3C, 8, 1'b0);
        frame(K_FREQ, 64'h1, 1, 1'b0);
        frame(K_FREQ, 64'hF1234, 20, 1'b0);
        frame(K_PHASE, 64'h5A, 8, 1'b1);
        frame(K_FREQ, 64'h0, 0, 1'b0);

        // Both selects raised together.
        freq_cs = 1'b1; phaseshift_cs = 1'b1;
        exp_q.push_back('{K_ERR, 16'h0000, -1});
        wait_cyc(6);
        chk("busy_abort_both", {31'd0, busy}, 32'd1);
        freq_cs = 1'b0; phaseshift_cs = 1'b0;
        wait_cyc(8);
        chk("busy_after_both", {31'd0, busy}, 32'd0);

        // Phase select intrudes on an open freq frame.
        freq_cs = 1'b1;
        wait_cyc(6);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        phaseshift_cs = 1'b1;
        exp_q.push_back('{K_ERR, 16'h0000, -1});
        send_bit(1'b1);
        freq_cs = 1'b0;
        wait_cyc(6);
        chk("busy_abort_wait", {31'd0, busy}, 32'd1);
        phaseshift_cs = 1'b0;
        wait_cyc(8);
        chk("busy_after_intrude", {31'd0, busy}, 32'd0);

        // Randomized frames.
        for (int k = 0; k < 24; k++) begin
            tgt = $urandom_range(0, 1);
            n   = $urandom_range(0, 24);
            v   = {$urandom, $urandom};
            v   = v & ((64'd1 << n) - 64'd1);
            frame(tgt, v, n, (n > 0) && ($urandom_range(0, 1) == 1));
            wait_cyc($urandom_range(0, 3));
        end

        // Reset in the middle of a frame.
        frame(K_FREQ, 64'hBEEF, 16, 1'b0);
        frame(K_PHASE, 64'h81, 8, 1'b0);
        wait_cyc(2);
        freq_cs = 1'b1;
        wait_cyc(6);
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset", {freq_word, phase_word, freq_valid, phase_valid, busy, frame_err, 4'd0}, 32'd0);
        exp_q.delete();
        mdl_freq = 16'h0000;
        mdl_phase = 8'h00;
        freq_cs = 1'b0;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(12);
        chk("busy_after_reset", {31'd0, busy}, 32'd0);
        frame(K_FREQ, 64'h0042, 16, 1'b0);

        wait_cyc(10);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
